// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches from a variable-latency memory,
// presents the instruction until retire, then advances to PC+4 or the branch target.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      Instr,
    output logic             instr_valid,
    input  logic             retire,
    input  logic             PCSrc,
    input  logic [31:0]      PCTarget,
    output logic [31:0]      PC,
    output logic [31:0]      PCPlus8,
    output logic             misalign,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        EXEC = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [31:0]      pc_next;
    logic [31:0]      instr_next;
    logic             misalign_next;
    logic [CNT_W-1:0] count_next;
    logic             req_next;
    logic             valid_next;

    // State register; req/valid are registered from the next state so they track it exactly
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            PC          <= RESET_PC;
            Instr       <= 32'd0;
            misalign    <= 1'b0;
            instr_count <= '0;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
        end else begin
            state       <= state_next;
            PC          <= pc_next;
            Instr       <= instr_next;
            misalign    <= misalign_next;
            instr_count <= count_next;
            imem_req    <= req_next;
            instr_valid <= valid_next;
        end
    end

    // Next-state and datapath updates; everything holds unless the current state acts
    always_comb begin
        state_next    = state;
        pc_next       = PC;
        instr_next    = Instr;
        misalign_next = misalign;
        count_next    = instr_count;

        case (state)
            IDLE: state_next = REQ;
            REQ: begin
                if (imem_ack) begin
                    instr_next = imem_rdata;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (retire) begin
                    if (PCSrc) begin
                        pc_next = {PCTarget[31:2], 2'b00};
                        if (PCTarget[1:0] != 2'b00) begin
                            misalign_next = 1'b1;
                        end
                    end else begin
                        pc_next = PC + 32'd4;
                    end
                    count_next = instr_count + CNT_W'(1);
                    state_next = REQ;
                end
            end
            default: state_next = IDLE;
        endcase

        req_next   = (state_next == REQ);
        valid_next = (state_next == EXEC);
    end

    assign imem_addr = PC;
    assign PCPlus8   = PC + 32'd8;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus queues the expected instruction view,
// a monitor compares it whenever a new instruction becomes valid.
module tb_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (RESET_PC = 0, 32-bit counter)
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] instr;
    logic        instr_valid;
    logic        retire = 1'b0;
    logic        pcsrc = 1'b0;
    logic [31:0] pctarget = 32'd0;
    logic [31:0] pc;
    logic [31:0] pcplus8;
    logic        misalign;
    logic [31:0] instr_count;

    // Wrap instance (RESET_PC at top of memory, 2-bit counter)
    logic        b_reset = 1'b1;
    logic        b_imem_req;
    logic [31:0] b_imem_addr;
    logic        b_imem_ack = 1'b0;
    logic [31:0] b_imem_rdata = 32'd0;
    logic [31:0] b_instr;
    logic        b_instr_valid;
    logic        b_retire = 1'b0;
    logic        b_pcsrc = 1'b0;
    logic [31:0] b_pctarget = 32'd0;
    logic [31:0] b_pc;
    logic [31:0] b_pcplus8;
    logic        b_misalign;
    logic [1:0]  b_instr_count;

    fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .Instr(instr),
        .instr_valid(instr_valid), .retire(retire), .PCSrc(pcsrc),
        .PCTarget(pctarget), .PC(pc), .PCPlus8(pcplus8), .misalign(misalign),
        .instr_count(instr_count)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(2)) dut_wrap (
        .clk(clk), .reset(b_reset), .imem_req(b_imem_req), .imem_addr(b_imem_addr),
        .imem_ack(b_imem_ack), .imem_rdata(b_imem_rdata), .Instr(b_instr),
        .instr_valid(b_instr_valid), .retire(b_retire), .PCSrc(b_pcsrc),
        .PCTarget(b_pctarget), .PC(b_pc), .PCPlus8(b_pcplus8), .misalign(b_misalign),
        .instr_count(b_instr_count)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pcplus8;
        logic [31:0] count;
        logic        mis;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_cnt = 32'd0;
    logic        exp_mis = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: each newly valid instruction is compared against the oldest queued entry
    logic prev_valid = 1'b0;
    exp_t mon_e;
    always @(negedge clk) begin
        if (instr_valid && !prev_valid) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected: got instr %h expected no fetch", instr);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_instr", instr, mon_e.instr);
                chk("sb_pc", pc, mon_e.pc);
                chk("sb_pcplus8", pcplus8, mon_e.pcplus8);
                chk("sb_count", instr_count, mon_e.count);
                chk("sb_misalign", 32'(misalign), 32'(mon_e.mis));
            end
        end
        prev_valid = instr_valid;
    end

    // Bounded wait for a request, then stall 'waits' cycles before acking with 'word'
    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] word,
                            input int waits, input bit retire_in_req);
        bit   ok = 1'b0;
        exp_t e;
        for (int i = 0; i < 20; i++) begin
            if (imem_req) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL req_timeout: got no imem_req expected request at %h", addr);
            return;
        end
        chk("imem_addr", imem_addr, addr);
        for (int i = 0; i < waits; i++) begin
            if (retire_in_req && i == 0) retire = 1'b1;
            @(negedge clk);
            retire = 1'b0;
            chk("req_held", 32'(imem_req), 32'd1);
            chk("addr_held", imem_addr, addr);
            chk("no_valid_in_req", 32'(instr_valid), 32'd0);
        end
        e.instr   = word;
        e.pc      = addr;
        e.pcplus8 = addr + 32'd8;
        e.count   = exp_cnt;
        e.mis     = exp_mis;
        sb.push_back(e);
        imem_ack   = 1'b1;
        imem_rdata = word;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
    endtask

    task automatic do_retire(input logic src, input logic [31:0] tgt);
        retire   = 1'b1;
        pcsrc    = src;
        pctarget = tgt;
        @(negedge clk);
        retire   = 1'b0;
        pcsrc    = 1'b0;
        pctarget = 32'd0;
        exp_cnt  = exp_cnt + 32'd1;
        if (src && tgt[1:0] != 2'b00) exp_mis = 1'b1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_req"}, 32'(imem_req), 32'd0);
        chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
        chk({tag, "_pc"}, pc, 32'd0);
        chk({tag, "_instr"}, instr, 32'd0);
        chk({tag, "_count"}, instr_count, 32'd0);
        chk({tag, "_misalign"}, 32'(misalign), 32'd0);
    endtask

    initial begin
        bit ok;

        // Reset state and zero-wait first fetch
        repeat (2) @(negedge clk);
        chk_reset_state("reset");
        reset = 1'b0;
        @(negedge clk);
        chk("req_rise", 32'(imem_req), 32'd1);
        do_fetch(32'h0, 32'hE3A0_1005, 0, 1'b0);
        chk("pcplus8_at0", pcplus8, 32'd8);

        // 3-cycle latency with an ignored retire during REQ
        do_retire(1'b1, 32'h10);
        do_fetch(32'h10, 32'hE280_0001, 3, 1'b1);

        // Sequential and taken-branch PC updates
        do_retire(1'b1, 32'h20);
        do_fetch(32'h20, 32'h1111_0000, 0, 1'b0);
        do_retire(1'b0, 32'hDEAD_BEEF);
        do_fetch(32'h24, 32'h2222_0000, 1, 1'b0);
        do_retire(1'b1, 32'h100);
        do_fetch(32'h100, 32'h3333_0000, 0, 1'b0);

        // Misaligned target: aligned PC, sticky flag
        do_retire(1'b1, 32'h203);
        do_fetch(32'h200, 32'h4444_0000, 0, 1'b0);
        do_retire(1'b0, 32'h0);
        do_fetch(32'h204, 32'h5555_0000, 2, 1'b0);

        // Reset while in REQ at 0x40, with a concurrent ack that must be overridden
        do_retire(1'b1, 32'h40);
        chk("req_at_40", 32'(imem_req), 32'd1);
        chk("addr_at_40", imem_addr, 32'h40);
        reset      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        reset      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        chk_reset_state("rst_req");
        exp_cnt = 32'd0;
        exp_mis = 1'b0;

        // Reset while in EXEC, with a concurrent retire that must be overridden
        do_fetch(32'h0, 32'h6666_0000, 0, 1'b0);
        reset    = 1'b1;
        retire   = 1'b1;
        pcsrc    = 1'b1;
        pctarget = 32'h303;
        @(negedge clk);
        reset    = 1'b0;
        retire   = 1'b0;
        pcsrc    = 1'b0;
        pctarget = 32'd0;
        chk_reset_state("rst_exec");

        // PC and counter wrap on the second instance
        b_reset = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            ok = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (b_imem_req) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) begin
                n_checks++;
                n_fail++;
                $display("FAIL wrap_req_timeout: got no imem_req expected request %0d", k);
                break;
            end
            if (k == 1) chk("wrap_addr", b_imem_addr, 32'hFFFF_FFFC);
            b_imem_ack   = 1'b1;
            b_imem_rdata = 32'hA000_0000 + 32'(k);
            @(negedge clk);
            b_imem_ack   = 1'b0;
            chk("wrap_valid", 32'(b_instr_valid), 32'd1);
            if (k == 1) chk("wrap_pcplus8", b_pcplus8, 32'h4);
            b_retire = 1'b1;
            @(negedge clk);
            b_retire = 1'b0;
            if (k == 1) chk("wrap_pc", b_pc, 32'h0);
            chk("wrap_count", 32'(b_instr_count), 32'(k % 4));
        end

        repeat (2) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
